lsu_mem_initiator: RTL and testbench

//  Load/store initiator driving the single-port word data memory (MemRead/MemWrite, word addr,

---
 rtl/lsu_mem_initiator.sv | 200 ++++++++++++++++++++
 tb/tb_lsu_mem_initiator.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: byte-addressed RV32I load/store initiator for a single-port
// word memory with combinational read. Splits each request into at most one word
// read and one word write, extends loads and read-modify-writes SB/SH.
// Optional feature: define LSU_MISALIGN_CHECK_EN to flag misaligned H/W accesses
// as errors; otherwise the low address bits below the access size are ignored.
module lsu_mem_initiator #(
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t              state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [31:0]         resp_rdata_q, resp_rdata_d;
  logic                resp_err_q, resp_err_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  // Only the parts of the request still needed after accept are kept.
  logic                we_q, we_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [1:0]          addr_lo_q, addr_lo_d;
  logic [15:0]         wdata_lo_q, wdata_lo_d;

  logic accept;
  logic illegal_err, range_err, misalign_err, req_err;

  // Select and extend the addressed lane of a fetched word.
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] lo);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lo, 3'b000} +: 8];
    h = w[{lo[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  // Merge store data into the fetched word for SB/SH.
  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [2:0] f3,
                                              input logic [1:0] lo, input logic [15:0] d);
    logic [31:0] m;
    m = w;
    if (f3[0]) m[{lo[1], 4'b0000} +: 16] = d;
    else       m[{lo, 3'b000} +: 8]      = d[7:0];
    return m;
  endfunction

  // Classify the incoming request before it is accepted.
  always_comb begin
    accept      = (state_q == S_IDLE) && req_valid;
    illegal_err = (req_funct3[1:0] == 2'b11) || (req_funct3[2:1] == 2'b11) ||
                  (req_we && req_funct3[2]);
    range_err   = (req_addr[31:ADDR_W+2] != '0) ||
                  ({1'b0, req_addr[ADDR_W+1:2]} >= DEPTH_L);
`ifdef LSU_MISALIGN_CHECK_EN
    misalign_err = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    misalign_err = 1'b0;
`endif
    req_err = illegal_err || range_err || misalign_err;
  end

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      we_q         <= 1'b0;
      funct3_q     <= '0;
      addr_lo_q    <= '0;
      wdata_lo_q   <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      addr_lo_q    <= addr_lo_d;
      wdata_lo_q   <= wdata_lo_d;
    end
  end

  // Next state: skip RD for SW, skip WR for loads, go straight to RESP on error.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_err)                         state_d = S_RESP;
          else if (req_we && req_funct3 == 3'b010) state_d = S_WR;
          else                                 state_d = S_RD;
        end
      end
      S_RD:    state_d = we_q ? S_WR : S_RESP;
      S_WR:    state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and the latched request fields.
  always_comb begin
    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    addr_lo_d    = addr_lo_q;
    wdata_lo_d   = wdata_lo_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d       = req_we;
          funct3_d   = req_funct3;
          addr_lo_d  = req_addr[1:0];
          wdata_lo_d = req_wdata[15:0];
          if (req_err) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            mem_addr_d = req_addr[ADDR_W+1:2];
            if (state_d == S_WR) begin
              mem_write_d = 1'b1;
              mem_wdata_d = req_wdata;
            end else begin
              mem_read_d = 1'b1;
            end
          end
        end
      end
      S_RD: begin
        if (we_q) begin
          mem_write_d = 1'b1;
          mem_wdata_d = store_merge(mem_rdata, funct3_q, addr_lo_q, wdata_lo_q);
        end else begin
          resp_valid_d = 1'b1;
          resp_rdata_d = load_ext(mem_rdata, funct3_q, addr_lo_q);
        end
      end
      S_WR:    resp_valid_d = 1'b1;
      default: ;
    endcase
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign MemRead    = mem_read_q;
  assign MemWrite   = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Testbench for lsu_mem_initiator: directed vector table, reset sequences and
// randomized requests checked against a byte-level reference memory model.
module tb_lsu_mem_initiator;

  localparam int ADDR_W = 9;
  localparam int DEPTH  = 128;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [2:0]        req_funct3 = 3'b0;
  logic [31:0]       req_addr = 32'h0;
  logic [31:0]       req_wdata = 32'h0;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] tb_mem [DEPTH] = '{default: 32'h0};
  logic [7:0]  ref_b  [4*DEPTH];

  lsu_mem_initiator #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .MemRead(mem_read), .MemWrite(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Word memory with combinational read.
  assign mem_rdata = (mem_addr < ADDR_W'(DEPTH)) ? tb_mem[mem_addr[6:0]] : 32'h0;
  always @(posedge clk) begin
    if (mem_write && mem_addr < ADDR_W'(DEPTH)) tb_mem[mem_addr[6:0]] <= mem_wdata;
  end

  // Read and write enables must never be asserted together.
  always @(negedge clk) begin
    if (mem_read === 1'b1 && mem_write === 1'b1) begin
      total++;
      bad++;
      $display("FAIL rw_exclusive actual=MemRead&MemWrite required=not_both");
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference model: byte-addressed memory, access size from funct3.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic err, output logic [31:0] rd,
                       output int lat, output int nrd, output int nwr,
                       output logic [31:0] word, output logic [8:0] idx);
    int size;
    longint ea;
    logic [31:0] v, mask;
    size = 1 << f3[1:0];
    err  = (f3 == 3'd3) || (f3 >= 3'd6) || (we && f3[2]) || (addr >= 32'(4*DEPTH));
`ifdef LSU_MISALIGN_CHECK_EN
    if (!err && (addr % size) != 0) err = 1'b1;
`endif
    ea   = longint'(addr) - longint'(addr % size);
    rd   = 32'h0;
    word = 32'h0;
    idx  = 9'(ea / 4);
    if (err) begin
      lat = 1; nrd = 0; nwr = 0;
    end else if (!we) begin
      lat = 2; nrd = 1; nwr = 0;
      v = 32'h0;
      for (int i = 0; i < size; i++) v = v | (32'(ref_b[int'(ea) + i]) << (8 * i));
      if (size < 4 && !f3[2]) begin
        mask = (32'h1 << (8 * size)) - 32'h1;
        if (v[8*size-1]) v = v | ~mask;
      end
      rd = v;
    end else begin
      for (int i = 0; i < size; i++) ref_b[int'(ea) + i] = wdata[8*i +: 8];
      for (int i = 0; i < 4; i++) word[8*i +: 8] = ref_b[int'(ea / 4) * 4 + i];
      lat = (size == 4) ? 2 : 3;
      nrd = (size == 4) ? 0 : 1;
      nwr = 1;
    end
  endtask

  // Issue one request and check response, latency and memory traffic.
  task automatic do_txn(input string nm, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rd, input int exp_lat,
                        input int exp_nrd, input int exp_nwr, input logic [31:0] exp_word,
                        input logic [8:0] exp_idx);
    int nrd, nwr, k;
    bit seen;
    @(negedge clk);
    chk({nm, ".ready"}, 32'(req_ready), 32'h1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    nrd = 0; nwr = 0; k = 0; seen = 0;
    for (int c = 1; c <= 8 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
      end
      if (mem_read === 1'b1) begin
        nrd++;
        chk({nm, ".rd_addr"}, 32'(mem_addr), 32'(exp_idx));
      end
      if (mem_write === 1'b1) begin
        nwr++;
        chk({nm, ".wr_addr"}, 32'(mem_addr), 32'(exp_idx));
        chk({nm, ".wr_data"}, mem_wdata, exp_word);
      end
      if (resp_valid === 1'b1) begin
        seen = 1; k = c;
      end
    end
    chk({nm, ".resp_seen"}, 32'(seen), 32'h1);
    chk({nm, ".latency"}, 32'(k), 32'(exp_lat));
    chk({nm, ".err"}, 32'(resp_err), 32'(exp_err));
    chk({nm, ".rdata"}, resp_rdata, exp_rd);
    chk({nm, ".n_read"}, 32'(nrd), 32'(exp_nrd));
    chk({nm, ".n_write"}, 32'(nwr), 32'(exp_nwr));
    $display("txn %s we=%0d f3=%0d addr=%h wdata=%h -> err=%0d rdata=%h lat=%0d",
             nm, we, f3, addr, wdata, resp_err, resp_rdata, k);
    @(negedge clk);
    chk({nm, ".pulse_end"}, 32'(resp_valid), 32'h0);
    chk({nm, ".ready_after"}, 32'(req_ready), 32'h1);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, ".req_ready"}, 32'(req_ready), 32'h1);
    chk({nm, ".resp_valid"}, 32'(resp_valid), 32'h0);
    chk({nm, ".resp_rdata"}, resp_rdata, 32'h0);
    chk({nm, ".resp_err"}, 32'(resp_err), 32'h0);
    chk({nm, ".MemRead"}, 32'(mem_read), 32'h0);
    chk({nm, ".MemWrite"}, 32'(mem_write), 32'h0);
    chk({nm, ".mem_addr"}, 32'(mem_addr), 32'h0);
    chk({nm, ".mem_wdata"}, mem_wdata, 32'h0);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t vecs[17];

  initial begin
    logic        m_err;
    logic [31:0] m_rd, m_word;
    logic [8:0]  m_idx;
    int          m_lat, m_nrd, m_nwr;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_addr, r_wdata;

    for (int i = 0; i < 4 * DEPTH; i++) ref_b[i] = 8'h00;

    vecs[0]  = '{1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0,        2};
    vecs[1]  = '{1'b0, 3'b010, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF, 2};
    vecs[2]  = '{1'b1, 3'b000, 32'h11,  32'h00000080, 1'b0, 32'h0,        3};
    vecs[3]  = '{1'b0, 3'b000, 32'h11,  32'h0,        1'b0, 32'hFFFFFF80, 2};
    vecs[4]  = '{1'b0, 3'b100, 32'h11,  32'h0,        1'b0, 32'h00000080, 2};
    vecs[5]  = '{1'b1, 3'b001, 32'h12,  32'h00001234, 1'b0, 32'h0,        3};
    vecs[6]  = '{1'b0, 3'b001, 32'h12,  32'h0,        1'b0, 32'h00001234, 2};
    vecs[7]  = '{1'b0, 3'b101, 32'h12,  32'h0,        1'b0, 32'h00001234, 2};
    vecs[8]  = '{1'b0, 3'b010, 32'h10,  32'h0,        1'b0, 32'h123480EF, 2};
`ifdef LSU_MISALIGN_CHECK_EN
    vecs[9]  = '{1'b0, 3'b010, 32'h13,  32'h0,        1'b1, 32'h0,        1};
`else
    vecs[9]  = '{1'b0, 3'b010, 32'h13,  32'h0,        1'b0, 32'h123480EF, 2};
`endif
    vecs[10] = '{1'b0, 3'b011, 32'h10,  32'h0,        1'b1, 32'h0,        1};
    vecs[11] = '{1'b0, 3'b010, 32'h200, 32'h0,        1'b1, 32'h0,        1};
    vecs[12] = '{1'b1, 3'b100, 32'h10,  32'hFF,       1'b1, 32'h0,        1};
    vecs[13] = '{1'b1, 3'b000, 32'h1FF, 32'h000000A5, 1'b0, 32'h0,        3};
    vecs[14] = '{1'b0, 3'b000, 32'h1FF, 32'h0,        1'b0, 32'hFFFFFFA5, 2};
    vecs[15] = '{1'b0, 3'b010, 32'h80000010, 32'h0,   1'b1, 32'h0,        1};
    vecs[16] = '{1'b0, 3'b110, 32'h10,  32'h0,        1'b1, 32'h0,        1};

    // Reset held for two edges with a request pending.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10;
    req_wdata = 32'h55AA55AA;
    @(posedge clk);
    @(negedge clk);
    chk("rst1.MemWrite", 32'(mem_write), 32'h0);
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst2");
    req_valid = 1'b0;
    rst_n = 1'b1;

    // Directed vector table.
    foreach (vecs[i]) begin
      model(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
            m_err, m_rd, m_lat, m_nrd, m_nwr, m_word, m_idx);
      do_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_err, vecs[i].exp_rd, vecs[i].exp_lat, m_nrd, m_nwr, m_word, m_idx);
    end
    // The SB/SH sequence must leave the expected word behind.
    chk("word4_contents", tb_mem[4], 32'h123480EF);

    // Randomized requests against the reference model.
    for (int n = 0; n < 200; n++) begin
      r_we    = 1'($urandom);
      r_f3    = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) r_addr = $urandom;
      else r_addr = 32'($urandom_range(0, 4 * DEPTH + 40));
      r_wdata = $urandom;
      model(r_we, r_f3, r_addr, r_wdata, m_err, m_rd, m_lat, m_nrd, m_nwr, m_word, m_idx);
      do_txn($sformatf("rnd%0d", n), r_we, r_f3, r_addr, r_wdata,
             m_err, m_rd, m_lat, m_nrd, m_nwr, m_word, m_idx);
    end

    // Reset during the read phase of an SB aborts it: no write, no response.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h21;
    req_wdata = 32'h000000C3;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort.MemRead", 32'(mem_read), 32'h1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("abort.rst");
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("abort.no_write", 32'(mem_write), 32'h0);
      chk("abort.no_resp", 32'(resp_valid), 32'h0);
    end
    $display("txn abort SB addr=00000021 reset during read phase");
    model(1'b0, 3'b010, 32'h20, 32'h0, m_err, m_rd, m_lat, m_nrd, m_nwr, m_word, m_idx);
    do_txn("after_abort", 1'b0, 3'b010, 32'h20, 32'h0,
           m_err, m_rd, m_lat, m_nrd, m_nwr, m_word, m_idx);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
